eq_band_scheduler: RTL and testbench
====================================

# eq_band_scheduler

- Sequences one shared FIR filter engine across the N_BAND equalizer bands for each incoming audio sample.
- For each enabled band it issues a start to the engine, waits for the band result, and scales it by a per-band gain.
- It sums the scaled band outputs and produces one saturated 16-bit equalized sample.
- It sits between the audio sample source (new_data/x_in) and the output DAC path, and owns the per-band gain registers.

## Interface
- N_BAND, 5, number of bands (1..8)
- DW, 16, sample and engine data width
- GAIN_FRAC, 12, fractional bits of gain (Q4.12, unity = 0x1000)

- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- new_data  in  1  sample strobe; accepted only in IDLE
- x_in  in  DW  signed input sample
- band_mask  in  N_BAND  per-band enable; latched at sample acceptance
- gain_we  in  1  gain write strobe
- gain_addr  in  3  band index for gain write
- gain_wdata  in  16  signed Q4.12 gain
- ovr_clr  in  1  clears overrun flag
- eng_start  out  1  one-cycle engine start pulse
- eng_band  out  3  band (coefficient set) select for the engine
- eng_x  out  DW  latched sample presented to the engine
- eng_done  in  1  engine result valid; honoured only in WAIT
- eng_y  in  DW  signed engine band output
- y_out  out  DW  signed equalized sample, held until next result
- y_valid  out  1  one-cycle pulse when y_out updates
- busy  out  1  state != IDLE
- overrun  out  1  sticky flag: a sample was dropped

## Operation
- Reset values:
  - state IDLE
  - eng_start, eng_band, eng_x, y_out, y_valid, busy, overrun all 0
  - all gains (shadow and active) 0x1000
  - accumulator 0
- Gain bank:
  - gain_we writes the shadow register at gain_addr; writes with gain_addr >= N_BAND are ignored.
  - All shadows copy to active gains at sample acceptance.
  - A write in the acceptance cycle lands in the shadow only; it takes effect from the next sample.
- FSM states: IDLE, ISSUE, WAIT, ACC, OUT.
  - IDLE: if new_data is high, latch x_in into eng_x, latch band_mask, copy gains, clear acc, set band=0, go to ISSUE.
  - ISSUE:
    - If mask[band] is 0: skip the band. Go to OUT if band == N_BAND-1, else band++ and stay in ISSUE.
    - Otherwise: pulse eng_start with eng_band=band and go to WAIT.
  - WAIT: on eng_done, register prod = eng_y * gain_active[band] (signed 32-bit) and go to ACC. Otherwise hold.
  - ACC: acc += prod. Go to OUT if band == N_BAND-1, else band++ and go to ISSUE.
  - OUT: y_out <= sat_DW(acc >>> GAIN_FRAC), using arithmetic shift with truncation. Pulse y_valid and go to IDLE.
- Accumulator width is 32+3 bits signed; no intermediate overflow for N_BAND <= 8.
- Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- Overrun:
  - new_data while busy drops the sample and sets overrun.
  - The in-flight computation is unaffected.
  - ovr_clr clears overrun; a simultaneous set wins.
- eng_done outside WAIT is ignored.
- rst mid-operation returns to IDLE immediately with reset values; the engine is not re-started.

## Timing
- new_data is sampled at edge E0. ISSUE runs in cycle 1 and eng_start is high in cycle 1.
- An enabled band takes 2 + L cycles, where L (>= 1) is the number of WAIT cycles up to and including the eng_done cycle.
- A masked band takes 1 cycle.
- y_valid is high the cycle after OUT.
- All bands enabled, L=1: y_valid in cycle 17.
- band_mask = 0: y_valid in cycle 7, no eng_start.
- busy is high from cycle 1 through the OUT cycle.
- new_data is accepted again in the same cycle y_valid is high (state is IDLE).

## Structure
- Shared package eq_pkg holds:
  - N_BAND, GAIN_FRAC, UNITY_GAIN = 16'h1000
  - FSM state type
  - saturate-to-DW function
- Natural sub-module: eq_gain_bank, the shadow and active gain registers with write decode and commit strobe.

## Test plan
- Unity gains, all bands on, engine model returns eng_y=0x0800 one cycle after start → five eng_start pulses with eng_band 0..4, y_out=0x2800, y_valid in cycle 17.
- Saturation:
  - eng_y=0x7000 on all bands, unity gain → y_out=0x7FFF.
  - eng_y=0x9000 → y_out=0x8000.
- Gains:
  - Band 2 = 0x2000, others 0, eng_y=0x0100 → y_out=0x0200.
  - A band 2 write of 0x1000 in the same cycle as new_data → that sample still yields 0x0200; the next sample yields 0x0100.
- Masks:
  - band_mask=5'b00001 → exactly one eng_start with eng_band=0.
  - band_mask=0 → no eng_start, y_out=0 at cycle 7.
- Overrun:
  - new_data during WAIT → sample dropped, overrun=1, current y_out correct.
  - ovr_clr and a new overrun in the same cycle → overrun stays 1.
  - ovr_clr alone → overrun=0.
- Reset and stray done:
  - Assert rst during WAIT of band 3 → all outputs 0, gains 0x1000.
  - A stray eng_done after reset → no state change, no y_valid.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants, FSM state type and output saturation for the equalizer band scheduler.
package eq_pkg;

    localparam int N_BAND    = 5;
    localparam int DW        = 16;
    localparam int GAIN_FRAC = 12;
    localparam int GW        = 16;
    localparam int PROD_W    = 32;
    localparam int ACC_W     = PROD_W + 3;

    localparam logic [GW-1:0] UNITY_GAIN = 16'h1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACC,
        ST_OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Clamp a wide signed value into the signed DW-bit output range.
    function automatic logic [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Per-band gain registers: host writes land in shadows, which are copied
// to the active set on commit so a sample always sees one consistent gain set.
module eq_gain_bank #(
    parameter int N_BAND = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gain_we,
    input  logic [2:0]             gain_addr,
    input  logic [15:0]            gain_wdata,
    input  logic                   commit,
    output logic [N_BAND-1:0][15:0] gain_active
);
    import eq_pkg::*;

    logic [N_BAND-1:0][15:0] gain_shadow;

    // Shadow write decode and shadow-to-active commit; a same-cycle write misses the commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_shadow <= {N_BAND{UNITY_GAIN}};
            gain_active <= {N_BAND{UNITY_GAIN}};
        end else begin
            if (gain_we && (32'(gain_addr) < N_BAND)) begin
                gain_shadow[gain_addr] <= gain_wdata;
            end
            if (commit) begin
                gain_active <= gain_shadow;
            end
        end
    end

endmodule

// File: rtl/eq_band_scheduler.sv
// Time-multiplexes one FIR engine over the equalizer bands, applies
// per-band gains and emits one saturated equalized sample per input.
module eq_band_scheduler #(
    parameter int N_BAND    = 5,
    parameter int DW        = 16,
    parameter int GAIN_FRAC = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_data,
    input  logic [DW-1:0]     x_in,
    input  logic [N_BAND-1:0] band_mask,
    input  logic              gain_we,
    input  logic [2:0]        gain_addr,
    input  logic [15:0]       gain_wdata,
    input  logic              ovr_clr,
    output logic              eng_start,
    output logic [2:0]        eng_band,
    output logic [DW-1:0]     eng_x,
    input  logic              eng_done,
    input  logic [DW-1:0]     eng_y,
    output logic [DW-1:0]     y_out,
    output logic              y_valid,
    output logic              busy,
    output logic              overrun
);
    import eq_pkg::*;

    state_t                    state_q, state_d;
    logic [2:0]                band_q;
    logic [N_BAND-1:0]         mask_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [PROD_W-1:0]  prod_d;
    logic [N_BAND-1:0][15:0]   gain_active;
    logic                      accept;
    logic                      last_band;

    eq_gain_bank #(
        .N_BAND (N_BAND)
    ) u_gain_bank (
        .clk         (clk),
        .rst         (rst),
        .gain_we     (gain_we),
        .gain_addr   (gain_addr),
        .gain_wdata  (gain_wdata),
        .commit      (accept),
        .gain_active (gain_active)
    );

    assign last_band = (32'(band_q) == N_BAND - 1);
    assign prod_d    = $signed(eng_y) * $signed(gain_active[band_q]);
    assign eng_band  = band_q;
    assign busy      = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, sample acceptance and engine start pulse.
    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_data) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mask_q[band_q]) begin
                    state_d = last_band ? ST_OUT : ST_ISSUE;
                end else begin
                    eng_start = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                state_d = last_band ? ST_OUT : ST_ISSUE;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: sample latch, band counter, gain product, accumulation, output and overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_q  <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            eng_x   <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= (state_q == ST_OUT);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        eng_x  <= x_in;
                        mask_q <= band_mask;
                        acc_q  <= '0;
                        band_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (!mask_q[band_q] && !last_band) begin
                        band_q <= band_q + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        prod_q <= prod_d;
                    end
                end
                ST_ACC: begin
                    acc_q <= acc_q + ACC_W'(prod_q);
                    if (!last_band) begin
                        band_q <= band_q + 3'd1;
                    end
                end
                ST_OUT: begin
                    y_out <= sat_dw(acc_q >>> GAIN_FRAC);
                end
                default: begin
                end
            endcase
            // A sample arriving while busy is dropped; setting beats a simultaneous clear.
            if (new_data && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler with a simple fixed-latency FIR engine model.
module tb_eq_band_scheduler;

    logic        clk;
    logic        rst;
    logic        new_data;
    logic [15:0] x_in;
    logic [4:0]  band_mask;
    logic        gain_we;
    logic [2:0]  gain_addr;
    logic [15:0] gain_wdata;
    logic        ovr_clr;
    logic        eng_start;
    logic [2:0]  eng_band;
    logic [15:0] eng_x;
    logic        eng_done;
    logic [15:0] eng_y;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    int          n_tests;
    int          n_fail;
    int          n_start;
    logic [2:0]  start_band [0:15];
    logic [15:0] resp;
    int          eng_lat;
    logic        eng_auto;
    int          pending;
    int          cyc;

    eq_band_scheduler #(
        .N_BAND    (5),
        .DW        (16),
        .GAIN_FRAC (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_data   (new_data),
        .x_in       (x_in),
        .band_mask  (band_mask),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .ovr_clr    (ovr_clr),
        .eng_start  (eng_start),
        .eng_band   (eng_band),
        .eng_x      (eng_x),
        .eng_done   (eng_done),
        .eng_y      (eng_y),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Engine model: logs each start, answers with resp after eng_lat cycles.
    initial begin
        eng_done = 1'b0;
        eng_y    = '0;
        pending  = 0;
        n_start  = 0;
        forever begin
            @(negedge clk);
            if (eng_auto) begin
                eng_done = 1'b0;
                if (rst) begin
                    pending = 0;
                end else begin
                    if (pending > 0) begin
                        pending--;
                        if (pending == 0) begin
                            eng_done = 1'b1;
                            eng_y    = resp;
                        end
                    end
                    if (eng_start === 1'b1) begin
                        if (n_start < 16) start_band[n_start] = eng_band;
                        n_start++;
                        pending = eng_lat;
                    end
                end
            end
        end
    end

    task automatic wr_gain(input logic [2:0] addr, input logic [15:0] data);
        gain_we    = 1'b1;
        gain_addr  = addr;
        gain_wdata = data;
        @(negedge clk);
        gain_we    = 1'b0;
    endtask

    // Present one sample at the current negedge; cycles are counted from the acceptance edge.
    // Optionally injects new_data (with ovr_clr) or asserts rst at a chosen cycle.
    task automatic run(input logic [15:0] x, input logic [4:0] mask, input int inj_cyc,
                       input logic inj_clr, input int rst_cyc, output int c_out);
        n_start   = 0;
        x_in      = x;
        band_mask = mask;
        new_data  = 1'b1;
        c_out     = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            new_data = 1'b0;
            ovr_clr  = 1'b0;
            gain_we  = 1'b0;
            if (c == inj_cyc) begin
                new_data = 1'b1;
                x_in     = 16'h5555;
                ovr_clr  = inj_clr;
            end
            if (c == rst_cyc) begin
                rst   = 1'b1;
                c_out = c;
                break;
            end
            if (y_valid) begin
                c_out = c;
                break;
            end
        end
        if (c_out == 0) begin
            chk("result_timeout", 32'(c_out), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        new_data   = 1'b0;
        x_in       = '0;
        band_mask  = '0;
        gain_we    = 1'b0;
        gain_addr  = '0;
        gain_wdata = '0;
        ovr_clr    = 1'b0;
        resp       = 16'h0800;
        eng_lat    = 1;
        eng_auto   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_y_out",     32'(y_out),     32'h0);
        chk("rst_y_valid",   32'(y_valid),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_overrun",   32'(overrun),   32'h0);
        chk("rst_eng_start", 32'(eng_start), 32'h0);
        chk("rst_eng_band",  32'(eng_band),  32'h0);
        chk("rst_eng_x",     32'(eng_x),     32'h0);

        // Unity gains, all bands: 5 * 0x0800 = 0x2800.
        resp = 16'h0800;
        run(16'h1234, 5'b11111, 0, 1'b0, 0, cyc);
        chk("unity_y",      32'(y_out),   32'h2800);
        chk("unity_cycle",  32'(cyc),     32'd17);
        chk("unity_starts", 32'(n_start), 32'd5);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("unity_band%0d", b), 32'(start_band[b]), 32'(b));
        end
        chk("unity_eng_x",  32'(eng_x),   32'h1234);

        // Positive and negative saturation.
        resp = 16'h7000;
        run(16'h0001, 5'b11111, 0, 1'b0, 0, cyc);
        chk("sat_pos", 32'(y_out), 32'h7FFF);
        resp = 16'h9000;
        run(16'h0002, 5'b11111, 0, 1'b0, 0, cyc);
        chk("sat_neg", 32'(y_out), 32'h8000);

        // Only band 2 weighted at 2.0: 0x0100 * 2 = 0x0200.
        wr_gain(3'd0, 16'h0000);
        wr_gain(3'd1, 16'h0000);
        wr_gain(3'd2, 16'h2000);
        wr_gain(3'd3, 16'h0000);
        wr_gain(3'd4, 16'h0000);
        resp = 16'h0100;
        run(16'h0003, 5'b11111, 0, 1'b0, 0, cyc);
        chk("gain_b2", 32'(y_out), 32'h0200);

        // Gain write in the acceptance cycle only affects the following sample.
        gain_we    = 1'b1;
        gain_addr  = 3'd2;
        gain_wdata = 16'h1000;
        run(16'h0004, 5'b11111, 0, 1'b0, 0, cyc);
        chk("gain_same_cycle", 32'(y_out), 32'h0200);
        run(16'h0005, 5'b11111, 0, 1'b0, 0, cyc);
        chk("gain_next_sample", 32'(y_out), 32'h0100);

        // All bands masked.
        run(16'h0006, 5'b00000, 0, 1'b0, 0, cyc);
        chk("mask0_y",      32'(y_out),   32'h0);
        chk("mask0_cycle",  32'(cyc),     32'd7);
        chk("mask0_starts", 32'(n_start), 32'd0);

        // Only band 0 enabled at unity.
        for (int b = 0; b < 5; b++) wr_gain(3'(b), 16'h1000);
        resp = 16'h0800;
        run(16'h0007, 5'b00001, 0, 1'b0, 0, cyc);
        chk("mask1_y",      32'(y_out),         32'h0800);
        chk("mask1_starts", 32'(n_start),       32'd1);
        chk("mask1_band",   32'(start_band[0]), 32'd0);
        chk("mask1_cycle",  32'(cyc),           32'd9);

        // Sample dropped during WAIT; in-flight result unaffected.
        run(16'h1234, 5'b11111, 2, 1'b0, 0, cyc);
        chk("ovr_flag",  32'(overrun), 32'h1);
        chk("ovr_y",     32'(y_out),   32'h2800);
        chk("ovr_cycle", 32'(cyc),     32'd17);
        chk("ovr_eng_x", 32'(eng_x),   32'h1234);

        // Clear and new overrun together: set wins.
        run(16'h0008, 5'b11111, 5, 1'b1, 0, cyc);
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);

        // Reset during WAIT of band 3, with a pending gain change and an overrun.
        wr_gain(3'd0, 16'h3000);
        run(16'h0009, 5'b11111, 2, 1'b0, 11, cyc);
        chk("rst_at_cycle", 32'(cyc), 32'd11);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_y_out",    32'(y_out),    32'h0);
        chk("midrst_busy",     32'(busy),     32'h0);
        chk("midrst_overrun",  32'(overrun),  32'h0);
        chk("midrst_eng_x",    32'(eng_x),    32'h0);
        chk("midrst_eng_band", 32'(eng_band), 32'h0);

        // Stray eng_done in IDLE is ignored.
        eng_auto = 1'b0;
        @(negedge clk);
        eng_done = 1'b1;
        eng_y    = 16'h7000;
        @(negedge clk);
        eng_done = 1'b0;
        chk("stray_busy",    32'(busy),    32'h0);
        chk("stray_y_valid", 32'(y_valid), 32'h0);
        @(negedge clk);
        chk("stray_y_valid2", 32'(y_valid), 32'h0);
        chk("stray_y_out",    32'(y_out),   32'h0);
        eng_auto = 1'b1;

        // Gains restored to unity by reset (band 0 shadow of 0x3000 discarded).
        resp = 16'h0800;
        run(16'h000A, 5'b11111, 0, 1'b0, 0, cyc);
        chk("post_rst_y",     32'(y_out), 32'h2800);
        chk("post_rst_cycle", 32'(cyc),   32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
